// File: rtl/servo_pkg.sv
// Shared constants and state type for the servo ramp controller and its drive.
package servo_pkg;

  localparam int PERIOD_CYCLES_DEF = 10;
  localparam int MIN_PULSE_DEF     = 1;
  localparam int MAX_PULSE_DEF     = 9;
  localparam int STEP_DEF          = 2;
  localparam int RESET_PULSE_DEF   = 5;

  // The downstream drive's total frame time is the PWM period, by construction.
  localparam int DRIVE_TOTAL_TIME  = PERIOD_CYCLES_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } servo_state_e;

  function automatic logic [31:0] clamp_pulse(input logic [31:0] req,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    if (req < lo) return lo;
    if (req > hi) return hi;
    return req;
  endfunction

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Command handshake into the servo ramp controller.
// valid/ready: a command transfers on a rising edge where cmd_valid and cmd_ready are both high;
// while cmd_valid is high and cmd_ready low the source holds cmd_pulse unchanged.
interface servo_ramp_ctrl_if;
  logic        cmd_valid;
  logic [31:0] cmd_pulse;
  logic        cmd_ready;

  modport master (output cmd_valid, output cmd_pulse, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_pulse, output cmd_ready);
endinterface

// File: rtl/servo_period_timer.sv
// Free-running PWM period counter; period_tick marks the last clock of each period.
module servo_period_timer #(
  parameter int  PERIOD_CYCLES = servo_pkg::PERIOD_CYCLES_DEF,
  localparam int CW            = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1
) (
  input  logic          clock_clk,
  input  logic          reset_low,
  output logic [CW-1:0] count,
  output logic          period_tick
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign period_tick = (count == LAST);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Rate-limited servo pulse-width controller: accepts clamped targets through a one-entry
// pending slot and slews pulse_time by at most STEP per PWM period, only at period boundaries.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int  PERIOD_CYCLES = PERIOD_CYCLES_DEF,
  parameter int  MIN_PULSE     = MIN_PULSE_DEF,
  parameter int  MAX_PULSE     = MAX_PULSE_DEF,
  parameter int  STEP          = STEP_DEF,
  parameter int  RESET_PULSE   = RESET_PULSE_DEF,
  localparam int CW            = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1
) (
  input  logic                    clock_clk,
  input  logic                    reset_low,
  servo_ramp_ctrl_if.slave        cmd,
  output logic [31:0]             pulse_time,
  output logic                    period_tick,
  output logic                    at_target,
  output servo_state_e            state_dbg,
  output logic [CW-1:0]           count_dbg
);

  localparam logic [32:0] STEP33  = 33'(STEP);
  localparam logic [31:0] STEP32  = 32'(STEP);
  localparam logic [31:0] MIN32   = 32'(MIN_PULSE);
  localparam logic [31:0] MAX32   = 32'(MAX_PULSE);
  localparam logic [31:0] RESET32 = 32'(RESET_PULSE);

  servo_state_e state_q, state_d;
  logic [31:0]  pulse_q, pulse_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  pend_val_q, pend_val_d;
  logic         pend_full_q, pend_full_d;
  logic         accept;
  logic [32:0]  pulse_w, target_w, up_sum, down_gap;
  logic [31:0]  stepped;

  servo_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
    .clock_clk   (clock_clk),
    .reset_low   (reset_low),
    .count       (count_dbg),
    .period_tick (period_tick)
  );

  assign cmd.cmd_ready = !pend_full_q;
  assign accept        = cmd.cmd_valid && !pend_full_q;

  // 33-bit view so pulse+STEP cannot wrap when comparing against the target.
  assign pulse_w  = {1'b0, pulse_q};
  assign target_w = {1'b0, target_q};
  assign up_sum   = pulse_w + STEP33;
  assign down_gap = pulse_w - target_w;

  always_comb begin
    stepped = pulse_q;
    if (pulse_w < target_w) begin
      stepped = (up_sum >= target_w) ? target_q : up_sum[31:0];
    end else if (pulse_w > target_w) begin
      stepped = (down_gap <= STEP33) ? target_q : (pulse_q - STEP32);
    end
  end

  // Stepping uses the target held before this tick; a promotion lands one period later.
  always_comb begin
    state_d     = state_q;
    pulse_d     = pulse_q;
    target_d    = target_q;
    pend_full_d = pend_full_q;
    pend_val_d  = pend_val_q;
    if (accept) begin
      pend_full_d = 1'b1;
      pend_val_d  = clamp_pulse(cmd.cmd_pulse, MIN32, MAX32);
    end
    if (period_tick) begin
      pulse_d = stepped;
      if (pend_full_q) begin
        target_d    = pend_val_q;
        pend_full_d = 1'b0;
      end
      if (state_q == IDLE) begin
        if (target_d != pulse_d) state_d = RAMP;
      end else begin
        if (target_d == pulse_d) state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q     <= IDLE;
      pulse_q     <= RESET32;
      target_q    <= RESET32;
      pend_full_q <= 1'b0;
      pend_val_q  <= RESET32;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      target_q    <= target_d;
      pend_full_q <= pend_full_d;
      pend_val_q  <= pend_val_d;
    end
  end

  assign pulse_time = pulse_q;
  assign at_target  = (state_q == IDLE) && !pend_full_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Bench for servo_ramp_ctrl: expected per-tick pulse widths are queued when a command is
// driven and popped at each period boundary.
module tb_servo_ramp_ctrl;
  import servo_pkg::*;

  localparam int PERIOD = 10;
  localparam int BUDGET = 3 * PERIOD;

  // clock / reset
  logic         clock_clk = 1'b0;
  logic         reset_low;
  logic [31:0]  pulse_time;
  logic         period_tick;
  logic         at_target;
  servo_state_e state_dbg;
  logic [3:0]   count_dbg;

  servo_ramp_ctrl_if cmd ();

  servo_ramp_ctrl #(
    .PERIOD_CYCLES (PERIOD),
    .MIN_PULSE     (1),
    .MAX_PULSE     (9),
    .STEP          (2),
    .RESET_PULSE   (5)
  ) dut (
    .clock_clk   (clock_clk),
    .reset_low   (reset_low),
    .cmd         (cmd),
    .pulse_time  (pulse_time),
    .period_tick (period_tick),
    .at_target   (at_target),
    .state_dbg   (state_dbg),
    .count_dbg   (count_dbg)
  );

  always #5 clock_clk = ~clock_clk;

  // scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns at the negedge just after the next tick edge; pulse_time must not move before it.
  task automatic wait_tick_edge();
    logic [31:0] p0;
    logic        moved;
    int          n;
    p0    = pulse_time;
    moved = 1'b0;
    n     = 0;
    while (period_tick !== 1'b1 && n < BUDGET) begin
      @(negedge clock_clk);
      n++;
      if (pulse_time !== p0) moved = 1'b1;
    end
    check("tick_budget", 32'(n < BUDGET), 1);
    check("hold_between_ticks", 32'(moved), 0);
    @(negedge clock_clk);
  endtask

  task automatic drain(input string tag);
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      wait_tick_edge();
      e = exp_q.pop_front();
      check(tag, pulse_time, e);
    end
  endtask

  // driver: call at a negedge; returns at the negedge after the accepting edge
  task automatic send_cmd(input logic [31:0] v, output int waited);
    waited        = 0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_pulse = v;
    while (cmd.cmd_ready !== 1'b1 && waited < BUDGET) begin
      @(negedge clock_clk);
      waited++;
    end
    check("send_budget", 32'(waited < BUDGET), 1);
    @(negedge clock_clk);
    cmd.cmd_valid = 1'b0;
    cmd.cmd_pulse = 32'($urandom_range(0, 255));
  endtask

  initial begin
    int w;
    int cyc;
    reset_low     = 1'b0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_pulse = '0;
    repeat (3) @(negedge clock_clk);

    check("rst_pulse", pulse_time, 5);
    check("rst_ready", 32'(cmd.cmd_ready), 1);
    check("rst_tick", 32'(period_tick), 0);
    check("rst_at_target", 32'(at_target), 1);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_count", 32'(count_dbg), 0);

    // idle: 50 clocks, no commands, tick on every 10th clock
    reset_low = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      check("idle_tick", 32'(period_tick), 32'(c % PERIOD == 0));
      check("idle_pulse", pulse_time, 5);
      check("idle_at_target", 32'(at_target), 1);
      if (c < 50) @(negedge clock_clk);
    end
    wait_tick_edge();

    // ramp up 5 -> 9
    send_cmd(9, w);
    check("up_ready_low", 32'(cmd.cmd_ready), 0);
    check("up_at_target_low", 32'(at_target), 0);
    exp_q.push_back(5);
    drain("up_promote");
    check("up_ready_after_promote", 32'(cmd.cmd_ready), 1);
    check("up_state_ramp", 32'(state_dbg), 32'(RAMP));
    exp_q.push_back(7);
    exp_q.push_back(9);
    drain("up_step");
    check("up_state_idle", 32'(state_dbg), 32'(IDLE));
    check("up_at_target", 32'(at_target), 1);

    // clamp high, then step down, no overshoot, clamp low
    send_cmd(20, w);
    exp_q.push_back(9);
    drain("clamp_hi");
    check("clamp_hi_at_target", 32'(at_target), 1);
    check("clamp_hi_state", 32'(state_dbg), 32'(IDLE));
    send_cmd(5, w);
    exp_q.push_back(9); exp_q.push_back(7); exp_q.push_back(5);
    drain("down_to_5");
    send_cmd(4, w);
    exp_q.push_back(5); exp_q.push_back(4); exp_q.push_back(4);
    drain("no_overshoot");
    send_cmd(0, w);
    exp_q.push_back(4); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(1);
    drain("clamp_lo");
    check("clamp_lo_state", 32'(state_dbg), 32'(IDLE));
    check("clamp_lo_at_target", 32'(at_target), 1);

    // back-to-back: 8 then 2; second held until the tick that promotes 8
    send_cmd(8, w);
    check("b2b_ready_low", 32'(cmd.cmd_ready), 0);
    send_cmd(2, w);
    check("b2b_held_cycles", 32'(w), PERIOD - 1);
    check("b2b_pulse_at_accept", pulse_time, 1);
    exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(2);
    drain("b2b_reverse");
    check("b2b_at_target", 32'(at_target), 1);

    // reset mid-ramp at pulse 7 with a pending command
    send_cmd(1, w);
    exp_q.push_back(2); exp_q.push_back(1);
    drain("pre_reset_down");
    send_cmd(9, w);
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(7);
    drain("pre_reset_up");
    check("pre_reset_state", 32'(state_dbg), 32'(RAMP));
    send_cmd(3, w);
    check("pre_reset_pending", 32'(cmd.cmd_ready), 0);
    reset_low = 1'b0;
    #1;
    check("mid_rst_pulse", pulse_time, 5);
    check("mid_rst_ready", 32'(cmd.cmd_ready), 1);
    check("mid_rst_at_target", 32'(at_target), 1);
    check("mid_rst_tick", 32'(period_tick), 0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(negedge clock_clk);
    reset_low = 1'b1;
    cyc = 1;
    while (period_tick !== 1'b1 && cyc < BUDGET) begin
      @(negedge clock_clk);
      cyc++;
    end
    check("tick_after_release", 32'(cyc), PERIOD);
    exp_q.push_back(5); exp_q.push_back(5);
    drain("post_reset_hold");
    check("post_reset_at_target", 32'(at_target), 1);
    check("post_reset_ready", 32'(cmd.cmd_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/servo_ramp_ctrl.md
SERVO_RAMP_CTRL -- requirements
Module: servo_ramp_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 10, meaning PWM period length in clocks; it SHALL match the downstream servo drive's total time.
REQ-002 SHALL have parameter MIN_PULSE, default 1, meaning lowest legal pulse width in clocks.
REQ-003 SHALL have parameter MAX_PULSE, default 9, meaning highest legal pulse width in clocks.
REQ-004 SHALL have parameter STEP, default 2, meaning maximum pulse-width change per period.
REQ-005 SHALL have parameter RESET_PULSE, default 5, meaning neutral pulse width applied after reset.
REQ-006 SHALL have port clock_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 SHALL have port reset_low, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port cmd_valid, input, 1 bit: a target command is offered.
REQ-009 SHALL have port cmd_pulse, input, 32 bits: requested pulse width, unsigned.
REQ-010 SHALL have port cmd_ready, output, 1 bit: block can accept a command.
REQ-011 SHALL have port pulse_time, output, 32 bits: pulse width driven to the downstream servo drive.
REQ-012 SHALL have port period_tick, output, 1 bit: one-cycle strobe on the last clock of each period.
REQ-013 SHALL have port at_target, output, 1 bit: pulse_time equals the active target and no command is pending.

Function
REQ-014 Period counter SHALL count 0..PERIOD_CYCLES-1 and wrap to 0; period_tick SHALL be high when the count is PERIOD_CYCLES-1.
REQ-015 A command SHALL be accepted on a clock where cmd_valid and cmd_ready are both high; it SHALL be clamped to [MIN_PULSE, MAX_PULSE] and stored in a one-entry pending register.
REQ-016 cmd_ready SHALL be high exactly when the pending register is empty; cmd_valid while cmd_ready is low SHALL be ignored, and the source SHALL hold its command.
REQ-017 On period_tick with a pending command, the pending value SHALL become the active target and the pending register SHALL empty; cmd_ready SHALL be high on the next clock.
REQ-018 Acceptance and promotion on the same clock SHALL NOT occur, because cmd_ready is low while pending is full.
REQ-019 pulse_time SHALL change only on the clock edge that ends a period_tick cycle, so the downstream drive never sees a mid-period change.
REQ-020 On each period_tick, pulse_time SHALL move toward the active target as it stood before that tick's promotion: +STEP or -STEP, saturating at the target without overshoot.
REQ-021 A newly promoted target SHALL first affect pulse_time at the following tick, giving one period of latency from promotion to the first step.
REQ-022 FSM SHALL have states IDLE and RAMP. IDLE: pulse_time equals target. IDLE->RAMP when a promoted target differs from pulse_time. RAMP->IDLE on the tick where pulse_time reaches the target.
REQ-023 A new target arriving during RAMP SHALL retarget from the current pulse_time with no return to the start value.
REQ-024 Arithmetic SHALL be 33 bits wide internally, so pulse_time+STEP cannot wrap.
REQ-025 at_target SHALL be high iff the state is IDLE and the pending register is empty.

Reset
REQ-026 While reset_low is 0, asynchronously: pulse_time=RESET_PULSE, target=RESET_PULSE, counter=0, pending empty, state IDLE, cmd_ready=1, period_tick=0, at_target=1.
REQ-027 Reset mid-ramp SHALL discard the pending command and the target; after release, the first period_tick SHALL occur PERIOD_CYCLES clocks later.

Structure
REQ-028 Shared package servo_pkg SHALL hold the state enum (IDLE, RAMP) and the default constants for period, min, max, step and neutral pulse; the servo drive's total time SHALL reference the same period constant.
REQ-029 Period counter SHALL be a sub-module, servo_period_timer, with outputs count and period_tick.

Verification (PERIOD=10, MIN=1, MAX=9, STEP=2, RESET_PULSE=5)
REQ-030 Reset release, no commands, 50 clocks -> pulse_time stays 5, period_tick every 10th clock, at_target=1.
REQ-031 Command 9 -> after promotion, pulse_time 5->7->9 on successive ticks, never changes between ticks, then IDLE with at_target=1.
REQ-032 Command 20 -> clamped to 9; command 0 -> clamped to 1; command 4 from 5 -> single step to 4 with no overshoot to 3.
REQ-033 Two back-to-back cmd_valid with 8 then 2 -> second held with cmd_ready=0 until the next tick promotes 8, then accepted; ramp reverses toward 2 from the current value.
REQ-034 reset_low pulsed low mid-ramp at pulse_time=7 -> immediate pulse_time=5, cmd_ready=1, pending cleared, next tick 10 clocks after release.
